// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage: op codes, bus widths,
// FSM states and alignment helpers.
package mem_stage_pkg;

    typedef logic [3:0]  ExCode;
    typedef logic [31:0] MemAddrBus;
    typedef logic [31:0] MemBus;
    typedef logic [31:0] RegBus;
    typedef logic [4:0]  RegAddrBus;
    typedef logic [1:0]  MemIndex;
    typedef logic [3:0]  ByteEn;

    localparam ExCode EX_NOP = 4'h0;
    localparam ExCode EX_LB  = 4'h1;
    localparam ExCode EX_LH  = 4'h2;
    localparam ExCode EX_LW  = 4'h3;
    localparam ExCode EX_LBU = 4'h4;
    localparam ExCode EX_LHU = 4'h5;
    localparam ExCode EX_SB  = 4'h6;
    localparam ExCode EX_SH  = 4'h7;
    localparam ExCode EX_SW  = 4'h8;

    localparam int BUS_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_e;

    function automatic logic is_load(input ExCode op);
        return (op == EX_LB) || (op == EX_LH) || (op == EX_LW) ||
               (op == EX_LBU) || (op == EX_LHU);
    endfunction

    function automatic logic is_store(input ExCode op);
        return (op == EX_SB) || (op == EX_SH) || (op == EX_SW);
    endfunction

    // Halfword ops need an even lane, word ops need lane 0.
    function automatic logic is_misaligned(input ExCode op, input MemIndex idx);
        case (op)
            EX_LH, EX_LHU, EX_SH: return idx[0];
            EX_LW, EX_SW:         return idx != 2'd0;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-bus handshake between the memory stage (master) and memory (slave).
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic      req;
    logic      we;
    MemAddrBus addr;
    MemBus     wdata;
    ByteEn     be;
    logic      gnt;
    logic      rvalid;
    MemBus     rdata;

    modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);

endinterface

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  MemBus   rdata_i,
    input  MemIndex index_i,
    input  ExCode   op_i,
    output RegBus   data_o
);

    MemBus shifted;

    always_comb begin
        shifted = rdata_i >> {index_i, 3'b000};
        case (op_i)
            EX_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
            EX_LBU:  data_o = {24'd0, shifted[7:0]};
            EX_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
            EX_LHU:  data_o = {16'd0, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives the data-bus handshake for loads/stores, aligns
// load data and registers the write-back triple for WB.
//
// state | meaning
// IDLE  | accept a new op; non-memory ops pass straight to write-back
// REQ   | bus_req high, waiting for gnt (timed)
// WAIT  | granted, waiting for rvalid (timed)
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int BUS_TIMEOUT = BUS_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  ExCode       mem_op_i,
    input  logic        mem_req_i,
    input  MemAddrBus   mem_raddr_i,
    input  MemAddrBus   mem_waddr_i,
    input  MemBus       mem_wdata_i,
    input  MemIndex     r_index_i,
    input  MemIndex     w_index_i,
    input  RegBus       reg_wdata_i,
    input  logic        reg_we_i,
    input  RegAddrBus   reg_waddr_i,
    mem_stage_if.master bus,
    output RegBus       reg_wdata_o,
    output logic        reg_we_o,
    output RegAddrBus   reg_waddr_o,
    output logic        hold_flag_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam int TW = $clog2(BUS_TIMEOUT + 1);

    mem_state_e state_q;
    logic [TW-1:0] tmr_q;
    logic      req_q, we_q, misalign_q, bus_err_q, reg_we_q;
    MemAddrBus addr_q;
    MemBus     wdata_q;
    ByteEn     be_q;
    ExCode     op_q;
    MemIndex   idx_q;
    RegAddrBus dst_q;
    RegBus     reg_wdata_q;
    RegAddrBus reg_waddr_q;

    logic      load_d, store_d, misal_d, accept_d;
    MemIndex   idx_d;
    MemAddrBus addr_d;
    MemBus     wdata_d;
    ByteEn     be_d;
    RegBus     ld_data;

    always_comb begin
        load_d   = is_load(mem_op_i);
        store_d  = is_store(mem_op_i);
        idx_d    = store_d ? w_index_i : r_index_i;
        misal_d  = is_misaligned(mem_op_i, idx_d);
        accept_d = mem_req_i && (load_d || store_d) && !misal_d;
        addr_d   = (store_d ? mem_waddr_i : mem_raddr_i) & ~32'h3;
        case (mem_op_i)
            EX_SB: begin
                be_d    = ByteEn'(4'b0001 << w_index_i);
                wdata_d = {4{mem_wdata_i[7:0]}};
            end
            EX_SH: begin
                be_d    = ByteEn'(4'b0011 << w_index_i);
                wdata_d = {2{mem_wdata_i[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = mem_wdata_i;
            end
        endcase
    end

    load_align u_load_align (
        .rdata_i (bus.rdata),
        .index_i (idx_q),
        .op_i    (op_q),
        .data_o  (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            op_q        <= EX_NOP;
            idx_q       <= '0;
            dst_q       <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_wdata_q <= '0;
            reg_waddr_q <= '0;
        end else begin
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            reg_we_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_d || store_d) begin
                        if (mem_req_i && misal_d) begin
                            misalign_q <= 1'b1;
                        end else if (accept_d) begin
                            state_q <= REQ;
                            tmr_q   <= TW'(BUS_TIMEOUT - 1);
                            req_q   <= 1'b1;
                            we_q    <= store_d;
                            addr_q  <= addr_d;
                            wdata_q <= wdata_d;
                            be_q    <= be_d;
                            op_q    <= mem_op_i;
                            idx_q   <= idx_d;
                            dst_q   <= reg_waddr_i;
                        end
                    end else begin
                        reg_we_q    <= reg_we_i;
                        reg_wdata_q <= reg_wdata_i;
                        reg_waddr_q <= reg_waddr_i;
                    end
                end
                REQ, WAIT: begin
                    if ((state_q == REQ && bus.gnt && bus.rvalid) ||
                        (state_q == WAIT && bus.rvalid)) begin
                        state_q     <= IDLE;
                        tmr_q       <= '0;
                        req_q       <= 1'b0;
                        reg_we_q    <= !we_q;
                        reg_waddr_q <= dst_q;
                        if (!we_q) reg_wdata_q <= ld_data;
                    end else if (state_q == REQ && bus.gnt) begin
                        state_q <= WAIT;
                        tmr_q   <= TW'(BUS_TIMEOUT - 1);
                        req_q   <= 1'b0;
                    end else if (tmr_q == '0) begin
                        state_q   <= IDLE;
                        req_q     <= 1'b0;
                        bus_err_q <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hold_flag_o = (state_q != IDLE) || accept_d;

    assign bus.req     = req_q;
    assign bus.we      = we_q;
    assign bus.addr    = addr_q;
    assign bus.wdata   = wdata_q;
    assign bus.be      = be_q;
    assign reg_wdata_o = reg_wdata_q;
    assign reg_we_o    = reg_we_q;
    assign reg_waddr_o = reg_waddr_q;
    assign misalign_o  = misalign_q;
    assign bus_err_o   = bus_err_q;

endmodule
